res_pack: RTL

- Encoder counterpart to the distance-transform unpack path.
- Streams all 16384 bytes of the res image RAM (128x128, 8-bit per pixel), thresholds each byte to one bit, and packs 16 pixels per 16-bit word.
- Writes 1024 words to a binary-image output memory (sto), same layout as the sti ROM.
- Used to regenerate a binary image from res contents and count foreground pixels.

---
 rtl/res_pack.sv | 101 ++++++++++
 1 files changed

// File: rtl/res_pack.sv
// Thresholds every byte of the 128x128 res image to one bit, packs 16 pixels per
// word (lowest address in the MSB) into the sto memory and counts foreground pixels.
module res_pack #(
   parameter logic [7:0] THRESH = 8'd0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        res_rd,
   output logic [13:0] res_addr,
   input  logic [7:0]  res_di,
   output logic        sto_wr,
   output logic [9:0]  sto_addr,
   output logic [15:0] sto_do,
   output logic [14:0] ones_cnt
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

   state_t      state;
   logic        rd_q;
   logic [14:0] shreg;
   logic [3:0]  bit_cnt;
   logic [9:0]  word_cnt;
   logic        pix;

   assign pix = (res_di > THRESH);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         res_rd   <= 1'b0;
         res_addr <= '0;
         sto_wr   <= 1'b0;
         sto_addr <= '0;
         sto_do   <= '0;
         ones_cnt <= '0;
         rd_q     <= 1'b0;
         shreg    <= '0;
         bit_cnt  <= '0;
         word_cnt <= '0;
      end else begin
         sto_wr <= 1'b0;
         rd_q   <= res_rd;

         // res_di belongs to the address presented one cycle earlier
         if (rd_q) begin
            shreg    <= {shreg[13:0], pix};
            bit_cnt  <= bit_cnt + 4'd1;
            ones_cnt <= ones_cnt + {14'd0, pix};
            if (bit_cnt == 4'd15) begin
               sto_wr   <= 1'b1;
               sto_addr <= word_cnt;
               sto_do   <= {shreg, pix};
               word_cnt <= word_cnt + 10'd1;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= READ;
                  res_rd   <= 1'b1;
                  res_addr <= '0;
                  busy     <= 1'b1;
                  ones_cnt <= '0;
                  shreg    <= '0;
                  bit_cnt  <= '0;
                  word_cnt <= '0;
               end
            end
            READ: begin
               if (res_addr == '1) begin
                  state  <= DRAIN;
                  res_rd <= 1'b0;
               end else begin
                  res_addr <= res_addr + 14'd1;
               end
            end
            // first DRAIN cycle captures the last pixel (rd_q high), second writes the last word
            DRAIN: begin
               if (!rd_q) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
